// File: rtl/k_nns_ctrl.sv
// k_nns_ctrl: sequencer for a streaming k-nearest-neighbour core.
// A search loads the query into the core, streams n_pts points through it, and
// waits LAT cycles for the core pipeline to settle. It then captures the core's
// neighbour list and holds it until the consumer takes it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, query, n_pts      search request (accepted in IDLE only)
//   pt_valid/pt_ready,       input point stream
//   pt_data
//   core_rst, core_e_init,   core control: reset/query-load strobe, query,
//   core_g_input, core_gv    qualified point pass-through
//   core_o                   core neighbour list (K entries of 2*W bits)
//   result, res_valid/       captured neighbour list and its handshake
//   res_ready
//   busy                     high whenever not IDLE
//   stall_cnt                STREAM cycles without pt_valid (only when
//                            KNNS_CTRL_STATS_EN is defined)
module k_nns_ctrl #(
    parameter int unsigned W   = 32,
    parameter int unsigned K   = 8,
    parameter int unsigned CW  = 16,
    parameter int unsigned LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*W-1:0]       query,
    input  logic [CW-1:0]        n_pts,
    input  logic                 pt_valid,
    output logic                 pt_ready,
    input  logic [2*W-1:0]       pt_data,
    output logic                 core_rst,
    output logic [2*W-1:0]       core_e_init,
    output logic [2*W-1:0]       core_g_input,
    output logic                 core_gv,
    input  logic [2*W*K-1:0]     core_o,
    output logic [2*W*K-1:0]     result,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy
`ifdef KNNS_CTRL_STATS_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned LW = 2 * W * K;
    localparam int unsigned DW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        HOLD   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   query_q, query_d;
    logic [CW-1:0]   rem_q,   rem_d;
    logic [DW-1:0]   dcnt_q,  dcnt_d;
    logic [LW-1:0]   result_q, result_d;
`ifdef KNNS_CTRL_STATS_EN
    logic [31:0]     stall_q, stall_d;
`endif

    // Next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        query_d  = query_q;
        rem_d    = rem_q;
        dcnt_d   = dcnt_q;
        result_d = result_q;
`ifdef KNNS_CTRL_STATS_EN
        stall_d  = stall_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    query_d = query;
                    rem_d   = n_pts;
                    state_d = LOAD;
                end
            end
            LOAD: begin
`ifdef KNNS_CTRL_STATS_EN
                stall_d = 32'd0;
`endif
                // An empty search skips straight to draining the core pipeline
                if (rem_q == CW'(0)) begin
                    state_d = DRAIN;
                    dcnt_d  = DW'(LAT - 1);
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (pt_valid) begin
                    rem_d = rem_q - CW'(1);
                    if (rem_q == CW'(1)) begin
                        state_d = DRAIN;
                        dcnt_d  = DW'(LAT - 1);
                    end
                end
`ifdef KNNS_CTRL_STATS_EN
                else if (stall_q != 32'hFFFF_FFFF) begin
                    stall_d = stall_q + 32'd1;
                end
`endif
            end
            DRAIN: begin
                // Last drain cycle: the core list now reflects every streamed point
                if (dcnt_q == DW'(0)) begin
                    result_d = core_o;
                    state_d  = HOLD;
                end else begin
                    dcnt_d = dcnt_q - DW'(1);
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            query_q  <= '0;
            rem_q    <= '0;
            dcnt_q   <= '0;
            result_q <= '0;
`ifdef KNNS_CTRL_STATS_EN
            stall_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            query_q  <= query_d;
            rem_q    <= rem_d;
            dcnt_q   <= dcnt_d;
            result_q <= result_d;
`ifdef KNNS_CTRL_STATS_EN
            stall_q  <= stall_d;
`endif
        end
    end

    // Status outputs decoded from the state register
    assign pt_ready  = (state_q == STREAM);
    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == HOLD);
    assign result    = result_q;

    // Core interface: point pass-through is combinational so a point reaches the core the cycle it is accepted
    assign core_rst     = rst | (state_q == LOAD);
    assign core_e_init  = query_q;
    assign core_gv      = (state_q == STREAM) & pt_valid;
    assign core_g_input = core_gv ? pt_data : PW'(0);

`ifdef KNNS_CTRL_STATS_EN
    assign stall_cnt = stall_q;
`endif

endmodule
